// File: rtl/riscv_load_tag_tracker_pkg.sv
// rtl/riscv_load_tag_tracker_pkg.sv - shared types and encodings for the load tag tracker
//
// Purpose: byte count, data-type and phase encodings, FIFO entry layout and
// the phase FSM state type used by the tracker and its byte-select helper.
// Ports: none (package).
package riscv_load_tag_tracker_pkg;

  localparam int LSU_TAG_BYTES = 4;

  // data_type encodings (2'b10 and 2'b11 are both byte accesses)
  localparam logic [1:0] DTYPE_WORD = 2'b00;
  localparam logic [1:0] DTYPE_HALF = 2'b01;

  // misaligned phase encodings
  localparam logic [1:0] PHASE_SINGLE = 2'b00;
  localparam logic [1:0] PHASE_FIRST  = 2'b01;
  localparam logic [1:0] PHASE_SECOND = 2'b10;

  typedef enum logic {
    LT_IDLE    = 1'b0,
    LT_PARTIAL = 1'b1
  } load_tag_state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] dtype;
    logic [1:0] offset;
    logic [1:0] phase;
    logic       rs1_tag;
  } tag_entry_t;

  function automatic logic [1:0] encode_phase(input logic misaligned, input logic first);
    if (misaligned) return PHASE_SECOND;
    if (first)      return PHASE_FIRST;
    return PHASE_SINGLE;
  endfunction

endpackage

// File: rtl/riscv_load_tag_tracker_if.sv
// rtl/riscv_load_tag_tracker_if.sv - request/response/tag bundle between LSU, memory and tracker
//
// Purpose: groups the grant-time request attributes, the memory response and
// the tracker outputs.
// Modports: master = LSU/memory side (drives request and response, reads tags),
//           slave  = tracker side.
interface riscv_load_tag_tracker_if;
  logic       data_req_ex_i;
  logic       data_gnt_i;
  logic       data_we_ex_i;
  logic [1:0] data_type_ex_i;
  logic [1:0] data_addr_offset_ex_i;
  logic       data_misaligned_ex_i;
  logic       data_misaligned_first_ex_i;
  logic       rs1_tag_ex_i;
  logic       data_rvalid_i;
  logic [3:0] data_rdata_tag_i;
  logic       lsu_tag_stall_o;
  logic       regfile_wdata_tag_o;
  logic       rs1_tag_wb_o;
  logic       tag_valid_o;
  logic       protocol_err_o;

  modport master (
    output data_req_ex_i, data_gnt_i, data_we_ex_i, data_type_ex_i,
           data_addr_offset_ex_i, data_misaligned_ex_i, data_misaligned_first_ex_i,
           rs1_tag_ex_i, data_rvalid_i, data_rdata_tag_i,
    input  lsu_tag_stall_o, regfile_wdata_tag_o, rs1_tag_wb_o, tag_valid_o,
           protocol_err_o
  );

  modport slave (
    input  data_req_ex_i, data_gnt_i, data_we_ex_i, data_type_ex_i,
           data_addr_offset_ex_i, data_misaligned_ex_i, data_misaligned_first_ex_i,
           rs1_tag_ex_i, data_rvalid_i, data_rdata_tag_i,
    output lsu_tag_stall_o, regfile_wdata_tag_o, rs1_tag_wb_o, tag_valid_o,
           protocol_err_o
  );
endinterface

// File: rtl/riscv_tag_byte_select.sv
// rtl/riscv_tag_byte_select.sv - reduce per-byte memory tags to one load tag
//
// Purpose: builds the byte coverage mask of one memory response from the
// access type, address offset and misaligned phase, then ORs the covered tags.
// Ports: data_type_i (access size), offset_i (addr[1:0]), phase_i (single/
//        first/second), rdata_tag_i (per-byte tags), tag_o (reduced tag).
module riscv_tag_byte_select
  import riscv_load_tag_tracker_pkg::*;
(
  input  logic [1:0]               data_type_i,
  input  logic [1:0]               offset_i,
  input  logic [1:0]               phase_i,
  input  logic [LSU_TAG_BYTES-1:0] rdata_tag_i,
  output logic                     tag_o
);

  logic [LSU_TAG_BYTES-1:0] mask;

  always_comb begin
    mask = '0;
    case (data_type_i)
      DTYPE_WORD: begin
        // the first/single beat holds bytes offset..3, the second beat
        // holds the wrapped-around low bytes 0..offset-1
        for (int i = 0; i < LSU_TAG_BYTES; i++) begin
          if (phase_i == PHASE_SECOND) mask[i] = (2'(i) < offset_i);
          else                         mask[i] = (2'(i) >= offset_i);
        end
      end
      DTYPE_HALF: begin
        if (offset_i == 2'd3) mask = (phase_i == PHASE_SECOND) ? 4'b0001 : 4'b1000;
        else                  mask = 4'b0011 << offset_i;
      end
      default: mask = 4'b0001 << offset_i;
    endcase
  end

  assign tag_o = |(mask & rdata_tag_i);

endmodule

// File: rtl/riscv_load_tag_tracker.sv
// rtl/riscv_load_tag_tracker.sv - tracks outstanding data requests and produces load tags
//
// Purpose: records request attributes at grant, pops them on rvalid, reduces
// the per-byte response tag and merges the two halves of misaligned loads.
// Ports: clk, rst_n (async active-low), bus (slave modport: request fields,
//        response, stall, load tag, rs1 tag, tag valid, protocol error).
module riscv_load_tag_tracker
  import riscv_load_tag_tracker_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  riscv_load_tag_tracker_if.slave        bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  tag_entry_t       fifo [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  load_tag_state_t  state, state_next;
  logic             partial, partial_next;

  logic       empty, full, push, pop;
  tag_entry_t head, new_entry;
  logic       head_tag;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = bus.data_rvalid_i & ~empty;
  // a push into a full FIFO only fits when the head leaves in the same cycle
  assign push  = bus.data_req_ex_i & bus.data_gnt_i & (~full | pop);
  assign head  = fifo[rd_ptr];

  assign new_entry = '{we:      bus.data_we_ex_i,
                       dtype:   bus.data_type_ex_i,
                       offset:  bus.data_addr_offset_ex_i,
                       phase:   encode_phase(bus.data_misaligned_ex_i,
                                             bus.data_misaligned_first_ex_i),
                       rs1_tag: bus.rs1_tag_ex_i};

  riscv_tag_byte_select u_byte_select (
    .data_type_i (head.dtype),
    .offset_i    (head.offset),
    .phase_i     (head.phase),
    .rdata_tag_i (bus.data_rdata_tag_i),
    .tag_o       (head_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= LT_IDLE;
      partial <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      state   <= state_next;
      partial <= partial_next;
      if (push) begin
        fifo[wr_ptr] <= new_entry;
        wr_ptr       <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_next              = state;
    partial_next            = partial;
    bus.tag_valid_o         = 1'b0;
    bus.regfile_wdata_tag_o = 1'b0;
    bus.rs1_tag_wb_o        = 1'b0;
    bus.protocol_err_o      = 1'b0;

    if (bus.data_rvalid_i && empty) begin
      bus.protocol_err_o = 1'b1;
    end else if (pop && !head.we) begin
      if (state == LT_PARTIAL && head.phase == PHASE_SECOND) begin
        bus.tag_valid_o         = 1'b1;
        bus.regfile_wdata_tag_o = partial | head_tag;
        bus.rs1_tag_wb_o        = head.rs1_tag;
        partial_next            = 1'b0;
        state_next              = LT_IDLE;
      end else begin
        // an unexpected beat while waiting for a second half drops the
        // partial tag so it cannot leak into this load's result
        if (state == LT_PARTIAL) bus.protocol_err_o = 1'b1;
        partial_next = 1'b0;
        state_next   = LT_IDLE;
        case (head.phase)
          PHASE_SINGLE: begin
            bus.tag_valid_o         = 1'b1;
            bus.regfile_wdata_tag_o = head_tag;
            bus.rs1_tag_wb_o        = head.rs1_tag;
          end
          PHASE_FIRST: begin
            partial_next = head_tag;
            state_next   = LT_PARTIAL;
          end
          default: bus.protocol_err_o = 1'b1;  // second half with no first half
        endcase
      end
    end
  end

  assign bus.lsu_tag_stall_o = full;

endmodule

// File: doc/riscv_load_tag_tracker.md
Name: riscv_load_tag_tracker

Overview:
- Upstream neighbour of the load tag propagation stage, inside the LSU.
- Records per-request attributes (type, offset, misaligned phase, RS1 tag) at grant time and pops them on each rvalid.
- Reduces the 4-bit per-byte memory tag to a single load-data tag; merges the two halves of misaligned loads.
- Presents load-data tag and RS1 tag, aligned with the WB write, to the propagation logic.

Parameters:
- DEPTH, 2, outstanding transactions tracked (power of two, >=2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- data_req_ex_i  in  1  LSU request to data memory
- data_gnt_i  in  1  memory grant; push when req & gnt
- data_we_ex_i  in  1  1 = store (pushed for ordering, never produces a tag)
- data_type_ex_i  in  2  00 word, 01 half, 10/11 byte
- data_addr_offset_ex_i  in  2  address[1:0] of the original access
- data_misaligned_ex_i  in  1  1 = this grant is the second phase of a misaligned access
- data_misaligned_first_ex_i  in  1  1 = this grant is the first phase (a second follows)
- rs1_tag_ex_i  in  1  tag of the address source register
- data_rvalid_i  in  1  response valid
- data_rdata_tag_i  in  4  per-byte tags of returned word; bit i = byte i
- lsu_tag_stall_o  out  1  tracker full; EX must not issue
- regfile_wdata_tag_o  out  1  load-data tag
- rs1_tag_wb_o  out  1  RS1 tag of the completing load
- tag_valid_o  out  1  complete load tag valid this cycle
- protocol_err_o  out  1  one-cycle pulse: rvalid with empty tracker

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pointers 0, partial-tag register 0, phase state IDLE. All outputs 0.
  - Reset mid-transaction discards all entries.
  - A late rvalid after reset raises protocol_err_o and is otherwise ignored.
- FIFO entry: {we, type, offset, phase[1:0] (00 single, 01 first, 10 second), rs1_tag}.
  - Push on data_req_ex_i & data_gnt_i.
  - Pop on data_rvalid_i; head is always the oldest entry.
  - Count width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- Full/empty:
  - lsu_tag_stall_o = (count == DEPTH).
  - Push while full is accepted only if a pop occurs in the same cycle; count is unchanged.
  - Simultaneous push and pop when empty: pop is an error (protocol_err_o=1) and the push is still taken.
- Byte coverage mask from head entry:
  - Word, offset o: first/single phase covers bytes o..3; second phase covers bytes 0..o-1.
  - Half, offset o<3: bytes o,o+1. Half, offset 3: first phase byte 3, second phase byte 0.
  - Byte: byte o.
  - Tag = OR of data_rdata_tag_i over covered bytes.
- Phase FSM: states IDLE, PARTIAL.
  - IDLE, pop of load phase 00: tag_valid_o=1, regfile_wdata_tag_o=masked tag, rs1_tag_wb_o=head.rs1_tag (combinational, same cycle as rvalid).
  - IDLE, pop of load phase 01: store masked tag in partial register; go to PARTIAL; tag_valid_o=0.
  - PARTIAL, pop of phase 10: tag_valid_o=1, regfile_wdata_tag_o = partial | masked; clear partial; go to IDLE.
  - PARTIAL, pop of anything else: protocol_err_o=1, partial discarded, go to IDLE, then the entry is processed as from IDLE.
- Store pops: no tag_valid_o, FSM unchanged.
- Outputs are 0 whenever tag_valid_o=0.

Decomposition:
- riscv_defines additions:
  - LSU_TAG_BYTES=4
  - data-type encodings
  - phase encodings
  - FSM enum load_tag_state_t
- One natural sub-module: riscv_tag_byte_select, a combinational mask/reduce from (type, offset, phase, tag[3:0]) to 1 bit.
- Storage stays in the top module.

Test Plan:
- Word load, offset 0, rdata_tag=4'b0100, rs1_tag=1 -> same-cycle tag_valid_o=1, regfile_wdata_tag_o=1, rs1_tag_wb_o=1.
- Byte load, offset 2, rdata_tag=4'b1011 -> tag 0. Byte load, offset 3, same tag -> tag 1.
- Misaligned word, offset 3: first rvalid tag=4'b0111, second 4'b0000 -> no valid on first, tag 0 on second. Repeat with second=4'b0001 -> tag 1.
- Two back-to-back grants (load then store), DEPTH=2 -> stall_o=1 after the second grant. Simultaneous grant+rvalid keeps count at 2. Store pop gives no tag_valid_o.
- Load granted, rst_n pulsed low mid-wait, then rvalid -> protocol_err_o=1, tag_valid_o=0, stall_o=0.
- Misaligned half, offset 3, first tag=4'b1000, then a single-phase load response -> protocol_err_o=1 and single-load tag output unpolluted by partial.
